touch_sampler: RTL and testbench
================================

# touch_sampler

Sequencer that sits directly upstream of the touch SPI master. It detects pen-down on the touch controller's IRQ line and drives the master through alternating X and Y conversion commands. It extracts the 12-bit results, averages NUM_SAMPLES pairs, and presents one coordinate pair per frame to the cube-state UI logic.

## Interface
- NUM_SAMPLES, 4: X/Y pairs averaged per frame; power of two, 1..16
- DEBOUNCE_CYCLES, 2000: consecutive synchronized pen-down cycles required before sampling (2 ms at 1 MHz)
- GAP_CYCLES, 10000: idle cycles between frames while the pen stays down
- CMD_X, 8'hD0: X-measure command byte, controller bit order (MSB first on wire)
- CMD_Y, 8'h90: Y-measure command byte, controller bit order
- clk_1MHz  in  1  single clock, same domain as the SPI master
- rst_n  in  1  asynchronous active-low reset
- i_irq  in  1  controller pen IRQ, active low, asynchronous to clk_1MHz
- spi_busy  in  1  master busy
- spi_data_valid  in  1  master data_valid (level; high from DONE until next ENABLE)
- spi_data_out  in  16  master received word, MSB-first order
- spi_en  out  1  transaction request to the master
- spi_cmd  out  8  command byte to the master's data_in
- pen_down  out  1  debounced pen state
- touch_x  out  12  averaged X
- touch_y  out  12  averaged Y
- touch_valid  out  1  one-cycle pulse; touch_x/touch_y are updated on the same edge

## Operation
- i_irq passes through a 2-flop synchronizer, then a saturating debounce counter. pen_down rises after DEBOUNCE_CYCLES consecutive low samples. It falls immediately on the first synchronized high sample.
- The master shifts data_in[0] first, so spi_cmd = bit-reverse(CMD_*). Defaults give 8'h0B for X and 8'h09 for Y.
- Result = spi_data_out[14:3]. Bit 15 (the busy slot) and bits [2:0] are ignored.
- States:
  - IDLE: waits for pen_down → REQ_X.
  - REQ_X: spi_cmd = X command, spi_en = 1. Holds until spi_busy = 1, then drops spi_en → WAIT_X.
  - WAIT_X: waits for a rising edge of spi_data_valid (registered previous value). Adds the X result to the X accumulator → REQ_Y.
  - REQ_Y / WAIT_Y: same as the X pair with the Y command, adding to the Y accumulator. Increments the sample count. If count == NUM_SAMPLES → OUTPUT, else → REQ_X.
  - OUTPUT: touch_x = sum_x >> log2(NUM_SAMPLES), touch_y likewise. Pulses touch_valid, clears accumulators and count → GAP.
  - GAP: counts GAP_CYCLES → REQ_X if pen_down, else → IDLE.
- Accumulators are 12 + log2(NUM_SAMPLES) bits wide and never overflow. The shift truncates; there is no rounding.
- spi_en is only ever asserted in REQ_X/REQ_Y and only while spi_busy = 0 was last seen.
- Pen-up mid-frame:
  - An in-flight transaction (WAIT_*) must complete; the master cannot be aborted.
  - The partial frame is then discarded (accumulators and count cleared), no touch_valid is issued, → IDLE.
  - If pen-up occurs in REQ_* before busy is seen, spi_en drops and the block → IDLE.
- Pen-up during GAP → IDLE at the end of GAP; touch_x/touch_y hold their last values.

## Timing
- Reset values: spi_en 0, spi_cmd 8'h00, pen_down 0, touch_x 0, touch_y 0, touch_valid 0. The FSM starts in IDLE, and all counters and accumulators are 0.
- Pen-down latency: synchronized IRQ low → pen_down high after DEBOUNCE_CYCLES + 2 cycles.
- spi_en rises the cycle after entry to REQ_*. It falls the cycle after spi_busy is sampled high, typically 2–3 cycles.
- One master transaction is about 52 cycles. A frame is about NUM_SAMPLES × 2 × 55 cycles.
- touch_valid is high for exactly one cycle, on the OUTPUT cycle. Outputs hold until the next OUTPUT.
- Reset asserted mid-operation returns all state to the reset values within the same cycle (asynchronous). The master is reset by the same rst_n.

## Structure
- Shared package touch_pkg holds: state enum (IDLE, REQ_X, WAIT_X, REQ_Y, WAIT_Y, OUTPUT, GAP), default CMD_X/CMD_Y, the result bit slice constants (14, 3), and a bit-reverse function.
- One sub-module: touch_irq_debounce (synchronizer, debounce counter, pen_down output).

## Test plan
- Behavioural master model, NUM_SAMPLES = 4. Hold i_irq low, return spi_data_out = 16'h3E80 for every transaction → spi_cmd alternates 8'h0B/8'h09, then touch_x = touch_y = 12'h7D0, with one touch_valid pulse.
- X words 100<<3, 200<<3, 300<<3, 400<<3 and Y words all 4095<<3 → touch_x = 250, touch_y = 4095 (no overflow).
- i_irq low for DEBOUNCE_CYCLES − 10 cycles, then high → pen_down never rises and spi_en never asserts.
- i_irq released during the third WAIT_Y → that transaction completes, no touch_valid, return to IDLE, and the touch_x value from the previous frame is held.
- Model delays busy by 5 cycles → spi_en stays high until busy is seen, and exactly one transaction is issued per request.
- rst_n pulsed low in the middle of WAIT_X → every output is 0 immediately; after release with the pen still down, debounce restarts from 0.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types and constants for the touch sampling sequencer.
package touch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_X,
        WAIT_X,
        REQ_Y,
        WAIT_Y,
        OUTPUT,
        GAP
    } state_t;

    localparam logic [7:0]  CMD_X_DEFAULT = 8'hD0;
    localparam logic [7:0]  CMD_Y_DEFAULT = 8'h90;

    // Conversion result sits below the busy slot in the 16-bit word.
    localparam int unsigned RES_MSB = 14;
    localparam int unsigned RES_LSB = 3;
    localparam int unsigned RES_W   = RES_MSB - RES_LSB + 1;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/touch_sampler_if.sv
// Command/result handshake between the touch sequencer and the SPI master.
interface touch_sampler_if;

    logic        en;
    logic [7:0]  cmd;
    logic        busy;
    logic        data_valid;
    logic [15:0] data_out;

    modport master (
        output en,
        output cmd,
        input  busy,
        input  data_valid,
        input  data_out
    );

    modport slave (
        input  en,
        input  cmd,
        output busy,
        output data_valid,
        output data_out
    );

endinterface

// File: rtl/touch_irq_debounce.sv
// Pen IRQ synchronizer and saturating debounce; pen_down drops on the first high sample.
module touch_irq_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000
) (
    input  logic clk_1MHz,
    input  logic rst_n,
    input  logic i_irq,
    output logic pen_down
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b11;
            cnt      <= '0;
            pen_down <= 1'b0;
        end else begin
            sync <= {sync[0], i_irq};
            if (sync[1]) begin
                cnt      <= '0;
                pen_down <= 1'b0;
            end else if (!pen_down) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    cnt      <= CNT_W'(DEBOUNCE_CYCLES);
                    pen_down <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/touch_sampler.sv
// Touch sequencer: issues alternating X/Y conversions to the SPI master and
// reports one averaged coordinate pair per frame while the pen is down.
module touch_sampler
    import touch_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 2000,
    parameter int unsigned GAP_CYCLES      = 10000,
    parameter logic [7:0]  CMD_X           = CMD_X_DEFAULT,
    parameter logic [7:0]  CMD_Y           = CMD_Y_DEFAULT
) (
    input  logic             clk_1MHz,
    input  logic             rst_n,
    input  logic             i_irq,
    touch_sampler_if.master  spi,
    output logic             pen_down,
    output logic [RES_W-1:0] touch_x,
    output logic [RES_W-1:0] touch_y,
    output logic             touch_valid
);

    localparam int unsigned LOG2_N = $clog2(NUM_SAMPLES);
    localparam int unsigned ACC_W  = RES_W + LOG2_N;
    localparam int unsigned CNT_W  = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    // Master shifts data_in[0] first, so commands go out bit-reversed.
    localparam logic [7:0] CMD_X_WIRE = bit_rev8(CMD_X);
    localparam logic [7:0] CMD_Y_WIRE = bit_rev8(CMD_Y);

    state_t             state;
    logic [ACC_W-1:0]   sum_x;
    logic [ACC_W-1:0]   sum_y;
    logic [CNT_W-1:0]   count;
    logic [GAP_W-1:0]   gap_cnt;
    logic               dv_q;
    logic               dv_rise;
    logic [RES_W-1:0]   result;
    logic [ACC_W-1:0]   sum_x_next;
    logic [ACC_W-1:0]   sum_y_next;
    logic               unused_bits;

    touch_irq_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_1MHz (clk_1MHz),
        .rst_n    (rst_n),
        .i_irq    (i_irq),
        .pen_down (pen_down)
    );

    assign result      = spi.data_out[RES_MSB:RES_LSB];
    assign unused_bits = ^{spi.data_out[15], spi.data_out[RES_LSB-1:0]};
    assign dv_rise     = spi.data_valid & ~dv_q;
    assign sum_x_next  = sum_x + ACC_W'(result);
    assign sum_y_next  = sum_y + ACC_W'(result);

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sum_x       <= '0;
            sum_y       <= '0;
            count       <= '0;
            gap_cnt     <= '0;
            dv_q        <= 1'b0;
            spi.en      <= 1'b0;
            spi.cmd     <= 8'h00;
            touch_x     <= '0;
            touch_y     <= '0;
            touch_valid <= 1'b0;
        end else begin
            dv_q        <= spi.data_valid;
            touch_valid <= 1'b0;
            case (state)
                IDLE: begin
                    spi.en <= 1'b0;
                    sum_x  <= '0;
                    sum_y  <= '0;
                    count  <= '0;
                    if (pen_down) state <= REQ_X;
                end
                REQ_X, REQ_Y: begin
                    if (!pen_down) begin
                        spi.en <= 1'b0;
                        state  <= IDLE;
                    end else if (spi.busy) begin
                        spi.en <= 1'b0;
                        state  <= (state == REQ_X) ? WAIT_X : WAIT_Y;
                    end else begin
                        spi.en  <= 1'b1;
                        spi.cmd <= (state == REQ_X) ? CMD_X_WIRE : CMD_Y_WIRE;
                    end
                end
                WAIT_X: begin
                    if (dv_rise) begin
                        if (!pen_down) begin
                            state <= IDLE;
                        end else begin
                            sum_x <= sum_x_next;
                            state <= REQ_Y;
                        end
                    end
                end
                WAIT_Y: begin
                    if (dv_rise) begin
                        if (!pen_down) begin
                            state <= IDLE;
                        end else begin
                            sum_y <= sum_y_next;
                            count <= count + CNT_W'(1);
                            // Publish on entry so touch_valid is high during OUTPUT.
                            if (count == CNT_W'(NUM_SAMPLES - 1)) begin
                                touch_x     <= RES_W'(sum_x >> LOG2_N);
                                touch_y     <= RES_W'(sum_y_next >> LOG2_N);
                                touch_valid <= 1'b1;
                                state       <= OUTPUT;
                            end else begin
                                state <= REQ_X;
                            end
                        end
                    end
                end
                OUTPUT: begin
                    sum_x   <= '0;
                    sum_y   <= '0;
                    count   <= '0;
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= pen_down ? REQ_X : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_touch_sampler.sv
// Randomized bench for touch_sampler against a behavioural SPI master and averaging model.
module tb_touch_sampler;

    localparam int unsigned NS   = 4;
    localparam int unsigned DEB  = 40;
    localparam int unsigned GAPC = 100;
    localparam int unsigned XFER = 48;

    logic        clk_1MHz = 1'b0;
    logic        rst_n    = 1'b0;
    logic        i_irq    = 1'b1;
    logic        pen_down;
    logic [11:0] touch_x;
    logic [11:0] touch_y;
    logic        touch_valid;

    touch_sampler_if spi ();

    touch_sampler #(
        .NUM_SAMPLES     (NS),
        .DEBOUNCE_CYCLES (DEB),
        .GAP_CYCLES      (GAPC)
    ) dut (
        .clk_1MHz    (clk_1MHz),
        .rst_n       (rst_n),
        .i_irq       (i_irq),
        .spi         (spi),
        .pen_down    (pen_down),
        .touch_x     (touch_x),
        .touch_y     (touch_y),
        .touch_valid (touch_valid)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural SPI master: one transaction per request, data_valid held until next start.
    int          busy_dly = 1;
    int          m_cnt    = 0;
    int          n_txn    = 0;
    logic [7:0]  m_cmd;
    logic [15:0] x_q[$];
    logic [15:0] y_q[$];
    logic [7:0]  cmd_log[$];

    function automatic logic [15:0] next_word(input logic [7:0] c);
        logic [15:0] w;
        w = 16'h3E80;
        if (c == 8'h0B && x_q.size() > 0) w = x_q.pop_front();
        else if (c == 8'h09 && y_q.size() > 0) w = y_q.pop_front();
        return w;
    endfunction

    always @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            spi.busy       <= 1'b0;
            spi.data_valid <= 1'b0;
            spi.data_out   <= '0;
            m_cnt          <= 0;
        end else if (m_cnt == 0) begin
            if (spi.en && !spi.busy) begin
                spi.data_valid <= 1'b0;
                m_cmd          <= spi.cmd;
                m_cnt          <= 1;
                n_txn          <= n_txn + 1;
                cmd_log.push_back(spi.cmd);
            end
        end else begin
            if (m_cnt == busy_dly) spi.busy <= 1'b1;
            if (m_cnt == busy_dly + int'(XFER)) begin
                spi.busy       <= 1'b0;
                spi.data_valid <= 1'b1;
                spi.data_out   <= next_word(m_cmd);
                m_cnt          <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Output/protocol monitor
    int   valid_cnt = 0;
    int   proto_err = 0;
    int   dbl_valid = 0;
    logic busy_q    = 1'b0;
    logic valid_q   = 1'b0;
    bit   en_seen   = 1'b0;
    bit   pen_seen  = 1'b0;

    always @(negedge clk_1MHz) begin
        if (touch_valid) valid_cnt++;
        if (touch_valid && valid_q) dbl_valid++;
        if (spi.busy && !busy_q && !spi.en) proto_err++;
        if (spi.busy && busy_q && spi.en) proto_err++;
        busy_q  = spi.busy;
        valid_q = touch_valid;
        if (spi.en) en_seen = 1'b1;
        if (pen_down) pen_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk_1MHz);
        #1;
    endtask

    task automatic wait_pen(input string tag, output int n);
        n = 0;
        while (!pen_down && n < int'(DEB) + 100) begin
            tick();
            n++;
        end
        check({tag, "_pen_down"}, 32'(pen_down), 32'd1);
    endtask

    int txn_mark = 0;

    task automatic wait_frame(input string tag, input int ex, input int ey);
        int start;
        int n;
        start = valid_cnt;
        n     = 0;
        while (valid_cnt == start && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, 32'(valid_cnt - start), 32'd1);
        check({tag, "_x"}, 32'(touch_x), 32'(ex));
        check({tag, "_y"}, 32'(touch_y), 32'(ey));
        check({tag, "_txns"}, 32'(n_txn - txn_mark), 32'(2 * NS));
        txn_mark = n_txn;
    endtask

    function automatic logic [15:0] mkword(input int v);
        logic [15:0] w;
        w       = 16'($urandom);
        w[14:3] = 12'(v);
        return w;
    endfunction

    task automatic gen_frame(output int ex, output int ey);
        int sx;
        int sy;
        int vx;
        int vy;
        sx = 0;
        sy = 0;
        for (int i = 0; i < int'(NS); i++) begin
            vx = int'($urandom_range(0, 4095));
            vy = int'($urandom_range(0, 4095));
            x_q.push_back(mkword(vx));
            y_q.push_back(mkword(vy));
            sx += vx;
            sy += vy;
        end
        ex = sx / int'(NS);
        ey = sy / int'(NS);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},    32'(spi.en),      32'd0);
        check({tag, "_cmd"},   32'(spi.cmd),     32'd0);
        check({tag, "_pen"},   32'(pen_down),    32'd0);
        check({tag, "_x"},     32'(touch_x),     32'd0);
        check({tag, "_y"},     32'(touch_y),     32'd0);
        check({tag, "_valid"}, 32'(touch_valid), 32'd0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ex;
        int ey;
        int prev_x;
        int prev_y;
        int base;
        int vstart;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Constant words, pen-down latency and command ordering
        i_irq = 1'b0;
        wait_pen("debounce", n);
        check("pen_latency", 32'(n), 32'(DEB + 2));
        txn_mark = n_txn;
        wait_frame("const", 12'h7D0, 12'h7D0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("cmd%0d", i), 32'(cmd_log[i]), (i % 2 == 0) ? 32'h0B : 32'h09);
        end
        tick();
        check("valid_width", 32'(touch_valid), 32'd0);

        // Directed averaging with junk in ignored bits
        for (int i = 0; i < int'(NS); i++) begin
            x_q.push_back(mkword(100 * (i + 1)));
            y_q.push_back(mkword(4095));
        end
        wait_frame("directed", 250, 4095);

        // Random frames; last one with a slow busy response
        for (int f = 0; f < 3; f++) begin
            if (f == 2) busy_dly = 5;
            gen_frame(ex, ey);
            wait_frame($sformatf("rand%0d", f), ex, ey);
        end
        busy_dly = 1;
        prev_x   = int'(touch_x);
        prev_y   = int'(touch_y);

        // Pen-up during GAP: back to IDLE, outputs hold
        i_irq   = 1'b1;
        en_seen = 1'b0;
        vstart  = valid_cnt;
        base    = n_txn;
        repeat (GAPC + 60) tick();
        check("gap_up_no_en", 32'(en_seen), 32'd0);
        check("gap_up_no_txn", 32'(n_txn - base), 32'd0);
        check("gap_up_no_valid", 32'(valid_cnt - vstart), 32'd0);
        check("gap_up_hold_x", 32'(touch_x), 32'(prev_x));

        // Pen-up during the third Y conversion
        i_irq = 1'b0;
        wait_pen("midframe", n);
        base = n_txn;
        n    = 0;
        while (!(n_txn == base + 6 && spi.busy) && n < 2000) begin
            tick();
            n++;
        end
        check("third_y_reached", 32'(n_txn - base), 32'd6);
        i_irq  = 1'b1;
        vstart = valid_cnt;
        n      = 0;
        while (!spi.data_valid && n < 200) begin
            tick();
            n++;
        end
        check("inflight_completes", 32'(spi.data_valid), 32'd1);
        repeat (300) tick();
        check("abort_txns", 32'(n_txn - base), 32'd6);
        check("abort_no_valid", 32'(valid_cnt - vstart), 32'd0);
        check("abort_hold_x", 32'(touch_x), 32'(prev_x));
        check("abort_hold_y", 32'(touch_y), 32'(prev_y));
        check("abort_en_low", 32'(spi.en), 32'd0);

        // Short IRQ glitch never qualifies
        pen_seen = 1'b0;
        en_seen  = 1'b0;
        i_irq    = 1'b0;
        repeat (DEB - 10) tick();
        i_irq = 1'b1;
        repeat (200) tick();
        check("glitch_no_pen", 32'(pen_seen), 32'd0);
        check("glitch_no_en", 32'(en_seen), 32'd0);

        // Asynchronous reset in the middle of WAIT_X
        i_irq = 1'b0;
        wait_pen("pre_reset", n);
        base = n_txn;
        n    = 0;
        while (!(n_txn == base + 1 && spi.busy) && n < 500) begin
            tick();
            n++;
        end
        check("wait_x_reached", 32'(n_txn - base), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk_1MHz);
        #1;
        rst_n = 1'b1;
        wait_pen("post_reset", n);
        check("post_reset_latency", 32'(n), 32'(DEB + 2));
        txn_mark = n_txn;
        wait_frame("post_reset", 12'h7D0, 12'h7D0);

        check("protocol_errors", 32'(proto_err), 32'd0);
        check("double_valid", 32'(dbl_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
